// File: rtl/hamming_rx_scheduler.sv
// hamming_rx_scheduler: buffers 7-bit codewords from the UART receiver and
// feeds them one at a time to the Hamming (7,4) decoder. Each decoder answer
// is awaited with a timeout and then offered on a valid/ready result port.
// Debug outputs: FIFO occupancy, a saturating error count and sticky flags.
module hamming_rx_scheduler #(
    parameter int DEPTH   = 4,   // FIFO entries, power of two, 2..8
    parameter int TIMEOUT = 8    // WAIT cycles before giving up, 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [6:0] rx_data,
    input  logic       rx_valid,
    output logic       dec_ena,
    output logic [6:0] dec_code,
    input  logic       dec_valid,
    input  logic [3:0] dec_data,
    input  logic [2:0] dec_syndrome,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic [2:0] out_syndrome,
    output logic [3:0] fifo_count,
    output logic [7:0] err_count,
    output logic       overrun,
    output logic       timeout
);

    localparam int         PTR_W      = $clog2(DEPTH);
    localparam logic [3:0] FULL_COUNT = 4'(DEPTH);
    localparam logic [7:0] LAST_WAIT  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    state_t           state;
    logic [7:0]       wait_cnt;
    logic [6:0]       code;
    logic [6:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             pop;
    logic             push;

    // The head leaves the FIFO at the end of the single ISSUE cycle. A push
    // into a full FIFO only fits when that pop happens in the same cycle.
    assign full = (fifo_count == FULL_COUNT);
    assign pop  = (state == ISSUE);
    assign push = rx_valid && (!full || pop);

    // The codeword register is loaded with the FIFO head on the way into
    // ISSUE. dec_code is therefore a flop output and stays valid through
    // ISSUE and WAIT, and dec_ena depends on the state register alone.
    assign dec_ena  = (state == ISSUE);
    assign dec_code = code;

    // Codeword storage, written on every accepted push.
    // NOTE: the storage array is deliberately not reset; the pointers and the occupancy count decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // FIFO pointers, occupancy and the sticky overrun flag.
    // NOTE: sequential state uses non-blocking assignments, so every flop here samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 4'd0;
            overrun    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 4'd1;
            end else if (!push && pop) begin
                fifo_count <= fifo_count - 4'd1;
            end
            if (rx_valid && !push) begin
                overrun <= 1'b1;
            end
        end
    end

    // Issue / wait / hold sequencer with registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= 8'd0;
            code         <= 7'd0;
            out_valid    <= 1'b0;
            out_data     <= 4'd0;
            out_syndrome <= 3'd0;
            err_count    <= 8'd0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ena && fifo_count != 4'd0) begin
                        code  <= mem[rd_ptr];
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= 8'd0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    // A result in the last allowed cycle still wins over the timeout.
                    if (dec_valid) begin
                        out_data     <= dec_data;
                        out_syndrome <= dec_syndrome;
                        out_valid    <= 1'b1;
                        if (dec_syndrome != 3'd0 && err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                        state <= HOLD;
                    end else if (wait_cnt == LAST_WAIT) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_rx_scheduler.sv
// Self-checking bench for hamming_rx_scheduler. A behavioural decoder answers
// after a chosen latency. A queue-based reference model predicts occupancy,
// issue order, flags, result timing and the error count cycle by cycle.
// Directed scenarios run first, followed by a randomized soak.
module tb_hamming_rx_scheduler;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [6:0] rx_data;
    logic       rx_valid;
    logic       dec_ena;
    logic [6:0] dec_code;
    logic       dec_valid;
    logic [3:0] dec_data;
    logic [2:0] dec_syndrome;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [2:0] out_syndrome;
    logic [3:0] fifo_count;
    logic [7:0] err_count;
    logic       overrun;
    logic       timeout;

    hamming_rx_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .dec_ena      (dec_ena),
        .dec_code     (dec_code),
        .dec_valid    (dec_valid),
        .dec_data     (dec_data),
        .dec_syndrome (dec_syndrome),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_syndrome (out_syndrome),
        .fifo_count   (fifo_count),
        .err_count    (err_count),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    initial forever #5 clk = ~clk;

    // Reference model state.
    logic [6:0] mq[$];          // words the FIFO should hold, head first
    logic [3:0] dat_q[$];       // preset decoder nibbles (random when empty)
    logic [2:0] syn_q[$];       // preset decoder syndromes (random when empty)
    logic [6:0] issued[$];      // words seen on dec_ena, in order
    int         issue_cyc[$];   // cycle index of each dec_ena
    logic       exp_ovr, exp_tmo, exp_ov;
    logic [3:0] exp_data;
    logic [2:0] exp_syn;
    logic [7:0] exp_err;
    logic [6:0] cur_code;
    int         hs_count;
    int         cyc = 0;
    int         tmo_cycle;
    int         wait_end;
    int         dec_lat;        // decoder answer delay in cycles after dec_ena, 0 = never
    int         pend;
    logic       pend_live;
    logic [3:0] pend_data;
    logic [2:0] pend_syn;
    logic       dec_live;
    logic       mon_en = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete(); dat_q.delete(); syn_q.delete();
        issued.delete(); issue_cyc.delete();
        exp_ovr = 1'b0; exp_tmo = 1'b0; exp_ov = 1'b0;
        exp_data = 4'd0; exp_syn = 3'd0; exp_err = 8'd0; cur_code = 7'd0;
        hs_count = 0; tmo_cycle = -1; wait_end = -1;
        pend = 0; pend_live = 1'b0; dec_valid = 1'b0; dec_live = 1'b0;
    endtask

    task automatic apply_reset();
        mon_en = 1'b0;
        rx_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    task automatic push_word(input logic [6:0] w);
        rx_valid = 1'b1;
        rx_data  = w;
        tick();
        rx_valid = 1'b0;
    endtask

    // Let every queued word finish, then allow the longest transaction to close.
    task automatic drain();
        int n = 0;
        rx_valid  = 1'b0;
        out_ready = 1'b1;
        ena       = 1'b1;
        while ((mq.size() != 0 || out_valid) && n < 500) begin
            tick();
            n++;
        end
        check("drain_bound", 32'(n < 500), 32'(1));
        repeat (2 * TIMEOUT + 8) tick();
    endtask

    // Behavioural decoder: answers dec_lat cycles after dec_ena; 0 or
    // anything beyond TIMEOUT means the scheduler should give up first.
    initial forever begin
        @(posedge clk);
        #2;
        dec_valid = 1'b0;
        dec_live  = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                dec_valid    = 1'b1;
                dec_live     = pend_live;
                dec_data     = pend_data;
                dec_syndrome = pend_syn;
            end
        end
        if (dec_ena) begin
            if (dat_q.size() > 0) pend_data = dat_q.pop_front();
            else pend_data = 4'($urandom);
            if (syn_q.size() > 0) pend_syn = syn_q.pop_front();
            else pend_syn = 3'($urandom);
            pend      = dec_lat;
            pend_live = (dec_lat >= 1) && (dec_lat <= TIMEOUT);
            wait_end  = pend_live ? cyc + dec_lat : cyc + TIMEOUT;
            if (!pend_live) tmo_cycle = cyc + TIMEOUT + 1;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Per-cycle comparison against the model, then advance the model to the next edge.
    task automatic monitor_cycle();
        if (cyc == tmo_cycle) exp_tmo = 1'b1;
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        check("timeout", 32'(timeout), 32'(exp_tmo));
        check("err_count", 32'(err_count), 32'(exp_err));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("out_data", 32'(out_data), 32'(exp_data));
        check("out_syndrome", 32'(out_syndrome), 32'(exp_syn));
        if (dec_ena) begin
            if (mq.size() == 0) begin
                check("spurious_issue", 32'(dec_ena), 32'(0));
            end else begin
                check("dec_code", 32'(dec_code), 32'(mq[0]));
                cur_code = mq[0];
                issued.push_back(mq.pop_front());
                issue_cyc.push_back(cyc);
            end
        end else if (cyc <= wait_end) begin
            check("dec_code_hold", 32'(dec_code), 32'(cur_code));
        end
        if (rx_valid) begin
            if (mq.size() < DEPTH) mq.push_back(rx_data);
            else exp_ovr = 1'b1;
        end
        if (out_valid && out_ready) begin
            hs_count++;
            exp_ov = 1'b0;
        end
        if (dec_valid && dec_live) begin
            exp_ov   = 1'b1;
            exp_data = dec_data;
            exp_syn  = dec_syndrome;
            if (dec_syndrome != 3'd0 && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        #3;
        if (mon_en) monitor_cycle();
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
        $fatal(1);
    end

    initial begin
        int n;
        int low;
        rst = 1'b1; ena = 1'b0; rx_valid = 1'b0; rx_data = 7'd0;
        dec_data = 4'd0; dec_syndrome = 3'd0; out_ready = 1'b0; dec_lat = 1;
        model_reset();
        apply_reset();
        check("reset_fifo_count", 32'(fifo_count), 32'(0));
        check("reset_dec_ena", 32'(dec_ena), 32'(0));

        // Single word: issue two cycles after the strobe, result at T+5.
        ena = 1'b1; out_ready = 1'b0; dec_lat = 2;
        dat_q.push_back(4'hA); syn_q.push_back(3'd0);
        rx_valid = 1'b1; rx_data = 7'h55;                  // cycle T
        tick(); rx_valid = 1'b0;                           // T+1
        check("sw_count_t1", 32'(fifo_count), 32'(1));
        tick();                                            // T+2
        check("sw_dec_ena", 32'(dec_ena), 32'(1));
        check("sw_dec_code", 32'(dec_code), 32'(7'h55));
        tick();                                            // T+3
        check("sw_count_t3", 32'(fifo_count), 32'(0));
        tick();                                            // T+4
        check("sw_out_valid_t4", 32'(out_valid), 32'(0));
        tick();                                            // T+5
        check("sw_out_valid_t5", 32'(out_valid), 32'(1));
        check("sw_out_data", 32'(out_data), 32'(4'hA));
        out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        check("sw_handshake_done", 32'(out_valid), 32'(0));
        check("sw_err_count", 32'(err_count), 32'(0));

        // Reset in the middle of WAIT with two words still queued.
        dec_lat = 0;
        push_word(7'h11); push_word(7'h22); push_word(7'h33);
        tick();
        check("rst_pre_count", 32'(fifo_count), 32'(2));
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_dec_ena", 32'(dec_ena), 32'(0));
        check("rst_dec_code", 32'(dec_code), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_syndrome", 32'(out_syndrome), 32'(0));
        check("rst_fifo_count", 32'(fifo_count), 32'(0));
        check("rst_err_count", 32'(err_count), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_timeout", 32'(timeout), 32'(0));
        tick(); tick();
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
        n = 0;
        repeat (8) begin
            tick();
            if (dec_ena) n++;
        end
        check("rst_no_issue", 32'(n), 32'(0));

        // Back-to-back words with an immediate decoder: four-cycle spacing.
        apply_reset();
        ena = 1'b0; dec_lat = 1; out_ready = 1'b1;
        push_word(7'h0A); push_word(7'h0B); push_word(7'h0C);
        drain();
        check("spacing_issues", 32'(issued.size()), 32'(3));
        check("spacing_1", 32'(issue_cyc[1] - issue_cyc[0]), 32'(4));
        check("spacing_2", 32'(issue_cyc[2] - issue_cyc[1]), 32'(4));

        // Error count with backpressure: five low-ready cycles per result.
        apply_reset();
        ena = 1'b1; dec_lat = 1; out_ready = 1'b0;
        syn_q.push_back(3'b101); syn_q.push_back(3'b000); syn_q.push_back(3'b011);
        push_word(7'h21); push_word(7'h42); push_word(7'h63);
        low = 0; n = 0;
        while (hs_count < 3 && n < 300) begin
            tick();
            n++;
            if (out_ready) begin
                out_ready = 1'b0;
            end else if (out_valid) begin
                if (low == 5) begin
                    out_ready = 1'b1;
                    low = 0;
                end else begin
                    low++;
                end
            end
        end
        tick();
        check("bp_handshakes", 32'(hs_count), 32'(3));
        check("bp_err_count", 32'(err_count), 32'(2));
        drain();

        // Full FIFO with a push in the ISSUE cycle: accepted, no overrun.
        apply_reset();
        ena = 1'b0; dec_lat = 1; out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_word(7'(8'h11 + i));
        ena = 1'b1;
        check("full_count", 32'(fifo_count), 32'(DEPTH));
        n = 0;
        while (!dec_ena && n < 10) begin
            tick();
            n++;
        end
        check("full_issue_seen", 32'(dec_ena), 32'(1));
        push_word(7'h15);
        check("full_pushpop_count", 32'(fifo_count), 32'(DEPTH));
        check("full_pushpop_overrun", 32'(overrun), 32'(0));
        drain();
        check("full_issued", 32'(issued.size()), 32'(DEPTH + 1));
        check("full_last_word", 32'(issued[DEPTH]), 32'(7'h15));

        // Overrun: five pushes into four entries with issue blocked.
        apply_reset();
        ena = 1'b0; dec_lat = 1; out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) push_word(7'(i));
        check("ovr_count", 32'(fifo_count), 32'(4));
        check("ovr_flag", 32'(overrun), 32'(1));
        drain();
        check("ovr_issued", 32'(issued.size()), 32'(4));
        for (int i = 0; i < 4; i++) check("ovr_order", 32'(issued[i]), 32'(i + 1));

        // Timeout: silent decoder, exact timing, next word proceeds, late answer ignored.
        apply_reset();
        ena = 1'b1; dec_lat = 0; out_ready = 1'b1;
        push_word(7'h2A); push_word(7'h2B);
        n = 0;
        while (issue_cyc.size() < 1 && n < 20) begin
            tick();
            n++;
        end
        check("to_first_issue", 32'(issue_cyc.size()), 32'(1));
        dec_lat = 1;
        n = 0;
        while (!timeout && n < 30) begin
            tick();
            n++;
        end
        check("to_delay", 32'(cyc - issue_cyc[0]), 32'(TIMEOUT + 1));
        n = 0;
        while (issue_cyc.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        check("to_next_issue", 32'(issued[1]), 32'(7'h2B));
        drain();
        check("to_next_handshake", 32'(hs_count), 32'(1));
        dec_lat = TIMEOUT + 4;
        push_word(7'h2C);
        drain();
        check("late_no_valid", 32'(out_valid), 32'(0));
        check("late_handshakes", 32'(hs_count), 32'(1));
        check("late_issued", 32'(issued.size()), 32'(3));

        // Randomized soak against the model.
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            rx_valid  = ($urandom_range(0, 2) == 0);
            rx_data   = 7'($urandom);
            ena       = ($urandom_range(0, 7) != 0);
            out_ready = 1'($urandom_range(0, 1));
            dec_lat   = int'($urandom_range(0, TIMEOUT));
            tick();
        end
        drain();
        check("soak_progress", 32'(hs_count > 10), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
